// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the host-to-local-bus write bridge.
// Covers header field positions, burst modes and host register selects.
package bus_bridge_pkg;

    localparam int MODE_BIT  = 28;
    localparam int COUNT_MSB = 27;
    localparam int COUNT_LSB = 16;
    localparam int ADDR_MSB  = 15;
    localparam int COUNT_W   = COUNT_MSB - COUNT_LSB + 1;

    typedef enum logic {
        MODE_W32 = 1'b0,
        MODE_W16 = 1'b1
    } mode_t;

    typedef enum logic {
        SEL_HDR  = 1'b0,
        SEL_DATA = 1'b1
    } sel_t;

endpackage

// File: rtl/bus_bridge.sv
// Narrow host write port to addressed local-bus write strobes.
// A header opens a burst; each data word becomes one 32-bit write or two 16-bit writes.
module bus_bridge
    import bus_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bn_data,
    input  logic        bn_addr,
    input  logic        bn_write,
    output logic [31:0] bw_data,
    output logic [15:0] bw_addr,
    output logic        bw_write,
    output logic        fault,
    output logic        complete
);

    logic [15:0]        next_addr  = '0;
    logic [COUNT_W-1:0] remaining  = '0;
    mode_t              mode       = MODE_W32;
    logic               hi_pend    = 1'b0;
    logic [15:0]        hi_addr    = '0;
    logic [15:0]        hi_data    = '0;
    logic [31:0]        bw_data_q  = '0;
    logic [15:0]        bw_addr_q  = '0;
    logic               bw_write_q = 1'b0;
    logic               fault_q    = 1'b0;
    logic               complete_q = 1'b1;

    logic               hdr_wr;
    logic               data_wr;
    logic               hdr_ok;
    logic               data_ok;
    logic               reject;
    logic [COUNT_W-1:0] hdr_count;
    logic               unused_hdr_bits;

    assign unused_hdr_bits = ^bn_data[31:29];

    always_comb begin
        hdr_wr    = bn_write && (bn_addr == SEL_HDR);
        data_wr   = bn_write && (bn_addr == SEL_DATA);
        hdr_count = bn_data[COUNT_MSB:COUNT_LSB];
        hdr_ok    = hdr_wr && complete_q;
        // The cycle that emits a pending high half owns the bus, so data is refused then.
        data_ok   = data_wr && (remaining != '0) && !hi_pend;
        reject    = (hdr_wr && !hdr_ok) || (data_wr && !data_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr  <= '0;
            remaining  <= '0;
            mode       <= MODE_W32;
            hi_pend    <= 1'b0;
            hi_addr    <= '0;
            hi_data    <= '0;
            bw_data_q  <= '0;
            bw_addr_q  <= '0;
            bw_write_q <= 1'b0;
            fault_q    <= 1'b0;
            complete_q <= 1'b1;
        end else begin
            bw_write_q <= 1'b0;
            fault_q    <= reject;
            // Evaluated on the current state so completion trails the final strobe by a cycle.
            complete_q <= (remaining == '0) && !hi_pend;

            if (hi_pend) begin
                bw_write_q <= 1'b1;
                bw_addr_q  <= hi_addr;
                bw_data_q  <= {16'h0000, hi_data};
                hi_pend    <= 1'b0;
            end

            if (hdr_ok) begin
                next_addr <= bn_data[ADDR_MSB:0];
                remaining <= hdr_count;
                mode      <= mode_t'(bn_data[MODE_BIT]);
                if (hdr_count != '0) begin
                    complete_q <= 1'b0;
                end
            end

            if (data_ok) begin
                bw_write_q <= 1'b1;
                bw_addr_q  <= next_addr;
                remaining  <= remaining - 1'b1;
                if (mode == MODE_W32) begin
                    bw_data_q <= bn_data;
                    next_addr <= next_addr + 16'd1;
                end else begin
                    bw_data_q <= {16'h0000, bn_data[15:0]};
                    hi_pend   <= 1'b1;
                    hi_addr   <= next_addr + 16'd1;
                    hi_data   <= bn_data[31:16];
                    next_addr <= next_addr + 16'd2;
                end
            end
        end
    end

    assign bw_data  = bw_data_q;
    assign bw_addr  = bw_addr_q;
    assign bw_write = bw_write_q;
    assign fault    = fault_q;
    assign complete = complete_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Bench for bus_bridge: a timeline model schedules expected strobes/faults per cycle,
// one negedge process compares every cycle, and literal tables pin the model.
module tb_bus_bridge;
    import bus_bridge_pkg::*;

    localparam int N = 512;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic [31:0] bn_data  = '0;
    logic        bn_addr  = 1'b0;
    logic        bn_write = 1'b0;
    logic [31:0] bw_data;
    logic [15:0] bw_addr;
    logic        bw_write;
    logic        fault;
    logic        complete;

    bus_bridge dut (
        .clk(clk), .rst(rst), .bn_data(bn_data), .bn_addr(bn_addr), .bn_write(bn_write),
        .bw_data(bw_data), .bw_addr(bw_addr), .bw_write(bw_write),
        .fault(fault), .complete(complete)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int idx = 0;

    // Expected timeline, indexed by the negedge at which an output becomes visible.
    bit          exp_w[N];
    bit          exp_f[N];
    bit          exp_rst[N];
    logic [15:0] exp_a[N];
    logic [31:0] exp_d[N];
    logic [15:0] held_a = '0;
    logic [31:0] held_d = '0;

    int          open_from = -1;
    int          close_at = -1;
    int          words_left = 0;
    logic [15:0] m_addr = '0;
    bit          m_mode = 1'b0;

    int          n_strobe = 0;
    int          n_fault = 0;
    logic [15:0] log_a[$];
    logic [31:0] log_d[$];

    logic [15:0] p1_addr[9] = '{16'h0010, 16'h0011, 16'h0012,
                                16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0025};
    logic [31:0] p1_data[9] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                32'h00001111, 32'h00002222, 32'h00003333,
                                32'h00004444, 32'h00005555, 32'h00006666};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, idx, got, want);
        end
    endtask

    function automatic bit m_complete(input int k);
        return !(open_from >= 0 && open_from <= k && (close_at < 0 || k < close_at));
    endfunction

    task automatic check_cycle();
        if (exp_rst[idx]) begin
            held_a = '0;
            held_d = '0;
        end
        if (exp_w[idx]) begin
            held_a = exp_a[idx];
            held_d = exp_d[idx];
        end
        chk("bw_write", 32'(bw_write), 32'(exp_w[idx]));
        chk("bw_addr", 32'(bw_addr), 32'(held_a));
        chk("bw_data", bw_data, held_d);
        chk("fault", 32'(fault), 32'(exp_f[idx]));
        chk("complete", 32'(complete), 32'(m_complete(idx)));
        if (bw_write) begin
            n_strobe++;
            log_a.push_back(bw_addr);
            log_d.push_back(bw_data);
        end
        if (fault) n_fault++;
    endtask

    task automatic model(input bit w, input bit sel, input logic [31:0] d, input bit r);
        int n;
        int last;
        n = idx;
        if (r) begin
            exp_rst[n+1] = 1'b1;
            exp_f[n+1] = 1'b0;
            for (int m = n + 1; m < N; m++) exp_w[m] = 1'b0;
            words_left = 0;
            if (open_from >= 0 && (close_at < 0 || close_at > n + 1)) close_at = n + 1;
            return;
        end
        if (!w) return;
        if (sel == 1'b0) begin
            if (m_complete(n)) begin
                m_addr = d[15:0];
                words_left = int'(d[27:16]);
                m_mode = d[28];
                if (words_left != 0) begin
                    open_from = n + 1;
                    close_at = -1;
                end
            end else begin
                exp_f[n+1] = 1'b1;
            end
        end else if (words_left == 0 || exp_w[n+1]) begin
            exp_f[n+1] = 1'b1;
        end else begin
            words_left--;
            exp_w[n+1] = 1'b1;
            exp_a[n+1] = m_addr;
            if (!m_mode) begin
                exp_d[n+1] = d;
                m_addr = m_addr + 16'd1;
                last = n + 1;
            end else begin
                exp_d[n+1] = {16'h0000, d[15:0]};
                exp_w[n+2] = 1'b1;
                exp_a[n+2] = m_addr + 16'd1;
                exp_d[n+2] = {16'h0000, d[31:16]};
                m_addr = m_addr + 16'd2;
                last = n + 2;
            end
            if (words_left == 0) close_at = last + 1;
        end
    endtask

    task automatic step(input bit w, input bit sel, input logic [31:0] d, input bit r);
        @(negedge clk);
        if (idx > 0) check_cycle();
        bn_write = w;
        bn_addr  = sel;
        bn_data  = d;
        rst      = r;
        model(w, sel, d, r);
        idx++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic hdr(input logic [31:0] d);
        step(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic dat(input logic [31:0] d);
        step(1'b1, 1'b1, d, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        idle(3);

        hdr(32'h00030010);
        idle(4); dat(32'h11111111);
        idle(4); dat(32'h22222222);
        idle(4); dat(32'h33333333);
        idle(5); dat(32'h44444444);
        idle(3);
        hdr(32'h10030020);
        hdr(32'h10030020);
        idle(3); dat(32'h22221111);
        idle(4); dat(32'h44443333);
        idle(4); dat(32'h66665555);
        idle(5);

        chk("p1_strobes", 32'(n_strobe), 32'd9);
        chk("p1_faults", 32'(n_fault), 32'd2);
        chk("p1_complete", 32'(complete), 32'd1);
        for (int i = 0; i < 9; i++) begin
            if (i < log_a.size()) begin
                chk("p1_log_addr", 32'(log_a[i]), 32'(p1_addr[i]));
                chk("p1_log_data", log_d[i], p1_data[i]);
            end else begin
                chk("p1_log_len", 32'(log_a.size()), 32'd9);
            end
        end

        hdr(32'h00000050);
        idle(2);
        chk("cnt0_complete", 32'(complete), 32'd1);
        dat(32'hAAAA5555);
        idle(2);
        hdr(32'h10020040);
        dat(32'hBBBBAAAA);
        dat(32'hDEADBEEF);
        idle(3);
        dat(32'hDDDDCCCC);
        idle(4);
        hdr(32'h0002FFFF);
        dat(32'h0000F00D);
        dat(32'h0000BEEF);
        idle(4);
        hdr(32'h10050100);
        idle(1);
        dat(32'h87654321);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        idle(4);
        dat(32'h12345678);
        idle(4);

        chk("p2_strobes", 32'(n_strobe), 32'd16);
        chk("p2_faults", 32'(n_fault), 32'd5);
        chk("p2_complete", 32'(complete), 32'd1);
        if (log_a.size() == 16) begin
            chk("w16_hi_addr", 32'(log_a[10]), 32'h0041);
            chk("w16_hi_data", log_d[10], 32'h0000BBBB);
            chk("w16_c_lo_addr", 32'(log_a[11]), 32'h0042);
            chk("wrap_addr0", 32'(log_a[13]), 32'hFFFF);
            chk("wrap_addr1", 32'(log_a[14]), 32'h0000);
            chk("wrap_data1", log_d[14], 32'h0000BEEF);
            chk("rst_last_addr", 32'(log_a[15]), 32'h0100);
            chk("rst_last_data", log_d[15], 32'h00004321);
        end else begin
            chk("p2_log_len", 32'(log_a.size()), 32'd16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_bridge.md
Name: bus_bridge

Overview:
- Narrow-to-wide write bridge: converts a 1-bit-addressed, 32-bit host write port (header register plus data FIFO-style port) into addressed 16-bit-address local-bus write strobes.
- A header write opens a burst: base address, word count and mode.
- Subsequent data writes are forwarded to consecutive local addresses, either as one 32-bit write per word or split into two 16-bit writes.
- Sits between a host register interface and the internal register bus; flags protocol errors and reports burst completion.

Parameters:
- none (field positions fixed in package)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- bn_data  input  32  host write data
- bn_addr  input  1  host register select: 0 = header, 1 = data
- bn_write  input  1  host write strobe, one word per cycle high
- bw_data  output  32  local-bus write data
- bw_addr  output  16  local-bus write address
- bw_write  output  1  local-bus write strobe
- fault  output  1  one-cycle protocol-error pulse
- complete  output  1  high when no burst is pending

Behaviour:
- Reset: bw_write=0, fault=0, complete=1, bw_addr=0, bw_data=0, remaining=0, no half pending.
- Same values also serve as register initial values, so an unconnected rst is harmless.
- Header format:
  - bit 28 = mode: 0 = 32-bit, 1 = 16-bit split.
  - bits 27:16 = count, number of 32-bit data words.
  - bits 15:0 = base address.
  - bits 31:29 are ignored.
- Header write (bn_write & bn_addr=0):
  - Accepted only when complete=1: loads next address=base, remaining=count and mode.
  - complete falls the next cycle if count!=0.
  - count=0 is accepted and leaves complete=1.
- Header while complete=0: rejected, burst state unchanged, fault=1 for one cycle, the cycle after.
- Data write (bn_write & bn_addr=1) while complete=1: rejected, no bw_write, fault pulse the cycle after.
- Data write in 32-bit mode:
  - The next cycle: bw_write=1, bw_addr=next address, bw_data=bn_data.
  - Then address+1 and remaining-1.
- Data write in 16-bit mode:
  - Cycle+1: bw_write=1, bw_addr=addr, bw_data={16'h0, bn_data[15:0]}.
  - Cycle+2: bw_write=1, bw_addr=addr+1, bw_data={16'h0, bn_data[31:16]}.
  - Address advances by 2; remaining-1 at the first half.
- Data write arriving during the cycle the second half is emitted: rejected with fault, state unchanged.
- complete = (remaining==0) and no second half pending; registered.
  - Falls the cycle after an accepted header with count!=0.
  - Rises the cycle after the final write strobe (for 16-bit mode, after the high half).
- bw_addr and bw_data hold their last values when bw_write=0.
- Address arithmetic is 16-bit modulo, wrapping 0xFFFF→0x0000.
- rst mid-burst aborts the burst: no further strobes, complete=1.
- fault and bw_write are never both caused by the same input write.

Decomposition:
- Package bus_bridge_pkg:
  - header field positions (MODE_BIT=28, COUNT_MSB=27, COUNT_LSB=16, ADDR_MSB=15).
  - mode constants MODE_W32=0, MODE_W16=1.
  - register-select constants SEL_HDR=0, SEL_DATA=1.
- Single flat module; no sub-module needed.
- Internal state: next address, remaining count, mode, pending high half plus its address, output registers.

Test Plan:
- Header 0x00030010 then data 0x11111111, 0x22222222, 0x33333333 five cycles apart -> writes (0x10,0x11111111), (0x11,0x22222222), (0x12,0x33333333); complete=1 afterwards.
- Fourth data word 0x44444444 after the 32-bit burst finishes -> no bw_write, one fault pulse.
- Header 0x10030020 followed next cycle by a duplicate header -> second header rejected with one fault; burst state unchanged.
- Data 0x22221111, 0x44443333, 0x66665555 -> six writes, addr 0x20..0x25, data low 16 bits 0x1111..0x6666 in order, upper 16 bits zero; complete=1 after the last.
- Whole sequence -> total 9 bw_write strobes and 2 fault pulses; complete high at quiescent checkpoints.
- Header count=0, 16-bit back-to-back data words, and rst asserted mid-burst -> respectively complete stays 1, second word faults, and strobes stop with complete=1.
